// File: rtl/btn_debounce_pulse_pkg.sv
// Shared types and constants for the push-button debounce front end.
// State encodings double as the LED debug code driven on state_dbg.
package btn_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_100MHZ_20MS = 2_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM         = 4;

endpackage

// File: rtl/btn_debounce_pulse_sync_nff.sv
// STAGES-deep flop chain bringing an asynchronous input into the clk_i domain.
// Asynchronous active-low reset clears every stage to 0.
module sync_nff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button synchroniser plus counter-based debounce FSM producing a clean level
// and one-cycle press/release strobes; all outputs are registered.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ_20MS,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] state_dbg
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (cp),
    .rst_ni(rst_n),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  // Entering a wait state loads 1 because the triggering sample is the first
  // of the DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (btn_sync) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_sync) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!btn_sync) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (btn_sync) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench: a run-length reference model predicts every cycle's outputs,
// a negedge monitor compares them; directed phases cover reset and bounce cases.
module tb_btn_debounce_pulse;
  import btn_debounce_pulse_pkg::*;

  localparam int unsigned D = DEBOUNCE_CYCLES_SIM;

  logic       cp;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
    .SYNC_STAGES    (2)
  ) dut (
    .cp           (cp),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .state_dbg    (state_dbg)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  // Reference model: the FSM sees btn_in from two edges earlier; the level flips
  // once D consecutive synchronised samples disagree with it.
  logic [4:0] expq[$];
  bit         hist[$] = '{1'b0, 1'b0};
  bit         m_level = 1'b0;
  int         m_run = 0;
  int         m_presses = 0, m_releases = 0;
  int         d_presses = 0, d_releases = 0;

  always @(posedge cp or negedge rst_n) begin
    bit s, p, r;
    if (!rst_n) begin
      m_level = 1'b0;
      m_run   = 0;
      hist    = '{1'b0, 1'b0};
      expq.delete();
    end else begin
      p = 1'b0;
      r = 1'b0;
      s = hist.pop_front();
      hist.push_back(btn_in);
      if (s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = ~m_level;
          p       = m_level;
          r       = ~m_level;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      if (p) m_presses++;
      if (r) m_releases++;
      expq.push_back({m_level, p, r, m_level, (m_run != 0)});
    end
  end

  always @(negedge cp) begin
    logic [4:0] exp_v, act_v;
    if (rst_n && expq.size() > 0) begin
      exp_v = expq.pop_front();
      act_v = {btn_level, press_pulse, release_pulse, state_dbg};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL outputs t=%0t {level,press,release,state} actual=%b required=%b",
                 $time, act_v, exp_v);
      end
      if (press_pulse) d_presses++;
      if (release_pulse) d_releases++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic drive(input bit val, input int n);
    btn_in = val;
    repeat (n) @(negedge cp);
  endtask

  task automatic async_reset_check(input string name);
    #2 rst_n = 1'b0;
    #1 chk(name, {27'd0, btn_level, press_pulse, release_pulse, state_dbg}, 32'd0);
    chk({name, "_cnt"}, 32'(dut.cnt_q), 32'd0);
    repeat (2) @(negedge cp);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(negedge cp);
    chk("reset_state", {27'd0, btn_level, press_pulse, release_pulse, state_dbg}, 32'd0);
    rst_n = 1'b1;

    drive(1'b0, 4);
    drive(1'b1, 10);            // clean press
    drive(1'b0, 2);             // release glitch, rejected
    drive(1'b1, 8);
    chk("glitch_level_held", {31'd0, btn_level}, 32'd1);
    drive(1'b0, 10);            // clean release
    drive(1'b1, 3);             // bounce burst, rejected
    drive(1'b0, 1);
    drive(1'b1, 10);
    chk("bounce_then_press", {31'd0, btn_level}, 32'd1);

    // asynchronous reset while PRESSED with the button held
    @(posedge cp);
    async_reset_check("reset_pressed");
    drive(1'b1, 10);
    chk("press_after_reset", {31'd0, btn_level}, 32'd1);

    // asynchronous reset in PRESS_WAIT with the counter at 2
    drive(1'b0, 10);
    btn_in = 1'b1;
    repeat (4) @(posedge cp);
    chk("wait_cnt_before_reset", {30'd0, state_dbg}, {30'd0, ST_PRESS_WAIT});
    async_reset_check("reset_midwait");
    drive(1'b1, 10);
    drive(1'b0, 10);

    // randomised bouncy runs around the debounce threshold
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * D + 1)));
    end
    drive(1'b0, 12);

    chk("press_count", d_presses, m_presses);
    chk("release_count", d_releases, m_releases);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
